// File: rtl/dp_pkg.sv
// Shared definitions for the bus datapath.
//   alu_op_e : ALU operation codes carried on alu_op
//   SEL_*    : bus-select offsets added to NREG for the non-register sources
package dp_pkg;

  typedef enum logic [3:0] {
    AluAdd      = 4'd0,
    AluSub      = 4'd1,
    AluAnd      = 4'd2,
    AluOr       = 4'd3,
    AluShr      = 4'd4,
    AluShra     = 4'd5,
    AluShl      = 4'd6,
    AluRor      = 4'd7,
    AluRol      = 4'd8,
    AluNeg      = 4'd9,
    AluNot      = 4'd10,
    AluMul      = 4'd11,
    AluReserved = 4'd12
  } alu_op_e;

  localparam int unsigned SEL_HI  = 0;
  localparam int unsigned SEL_LO  = 1;
  localparam int unsigned SEL_ZHI = 2;
  localparam int unsigned SEL_ZLO = 3;
  localparam int unsigned SEL_EXT = 4;

endpackage

// File: rtl/dp_mul.sv
// Iterative radix-2 signed shift-add multiplier.
//   clk, reset : clock, asynchronous active-low reset
//   start      : latch opA/opB and begin (ignored while busy)
//   opA, opB   : signed operands
//   busy       : iteration in progress (DATA_W cycles)
//   last       : final iteration edge is the next clock edge
//   product    : combinational next accumulator; full product while last is high
module dp_mul #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   opA,
  input  logic [DATA_W-1:0]   opB,
  output logic                busy,
  output logic                last,
  output logic [2*DATA_W-1:0] product
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic [2*DATA_W-1:0] accQ;
  logic [2*DATA_W-1:0] mcandQ;
  logic [2*DATA_W-1:0] addend;
  logic [DATA_W-1:0]   mplierQ;
  logic [CNT_W-1:0]    cntQ;
  logic                busyQ;

  assign busy = busyQ;
  assign last = busyQ && (cntQ == CNT_W'(DATA_W - 1));

  // The multiplier sign bit carries weight -2^(DATA_W-1), so the final step subtracts.
  always_comb begin
    addend = '0;
    if (mplierQ[0]) begin
      addend = last ? -mcandQ : mcandQ;
    end
    product = accQ + addend;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      accQ    <= '0;
      mcandQ  <= '0;
      mplierQ <= '0;
      cntQ    <= '0;
      busyQ   <= 1'b0;
    end else if (start && !busyQ) begin
      accQ    <= '0;
      mcandQ  <= {{DATA_W{opA[DATA_W-1]}}, opA};
      mplierQ <= opB;
      cntQ    <= '0;
      busyQ   <= 1'b1;
    end else if (busyQ) begin
      accQ    <= product;
      mcandQ  <= mcandQ << 1;
      mplierQ <= mplierQ >> 1;
      cntQ    <= cntQ + 1'b1;
      if (last) begin
        busyQ <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bus_datapath.sv
// Single-bus CPU datapath: register bank, HI/LO, Y, 2xDATA_W Z, single-cycle ALU and
// optional iterative signed multiplier. Build option: define DP_MUL_EN to include dp_mul;
// without it opcode MUL behaves as reserved and alu_busy is tied low.
//   clk, reset      : clock, asynchronous active-low reset
//   bus_sel         : bus source (registers, HI, LO, ZHI, ZLO, ext_in; others read 0)
//   ext_in          : external source
//   ba_zero         : register 0 reads as zero
//   reg_wr_en/addr  : load bus into a general register
//   y_in/hi_in/lo_in: load bus into Y / HI / LO
//   alu_op/alu_start: start Z <= op(Y, bus)
//   bus_out         : combinational bus value
//   alu_busy        : multiply in progress
//   alu_done        : one-cycle completion pulse
module bus_datapath
  import dp_pkg::*;
#(
  parameter int unsigned  DATA_W = 32,
  parameter int unsigned  NREG   = 16,
  localparam int unsigned SEL_W  = $clog2(NREG + 5)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        bus_sel,
  input  logic [DATA_W-1:0]       ext_in,
  input  logic                    ba_zero,
  input  logic                    reg_wr_en,
  input  logic [$clog2(NREG)-1:0] reg_wr_addr,
  input  logic                    y_in,
  input  logic                    hi_in,
  input  logic                    lo_in,
  input  logic [3:0]              alu_op,
  input  logic                    alu_start,
  output logic [DATA_W-1:0]       bus_out,
  output logic                    alu_busy,
  output logic                    alu_done
);

  localparam int unsigned RA_W = $clog2(NREG);
  localparam int unsigned SH_W = $clog2(DATA_W);

  localparam logic [SEL_W-1:0] CodeHi  = SEL_W'(NREG + SEL_HI);
  localparam logic [SEL_W-1:0] CodeLo  = SEL_W'(NREG + SEL_LO);
  localparam logic [SEL_W-1:0] CodeZhi = SEL_W'(NREG + SEL_ZHI);
  localparam logic [SEL_W-1:0] CodeZlo = SEL_W'(NREG + SEL_ZLO);
  localparam logic [SEL_W-1:0] CodeExt = SEL_W'(NREG + SEL_EXT);

`ifdef DP_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic [DATA_W-1:0]   regFile [NREG];
  logic [DATA_W-1:0]   hiQ, loQ, yQ, zHiQ, zLoQ;
  logic                doneQ;
  logic [DATA_W-1:0]   busVal;
  logic [DATA_W-1:0]   aluResult;
  logic [SH_W-1:0]     shAmt;
  logic [SH_W-1:0]     shInv;
  logic                startOk;
  logic                isMul;
  logic                mulBusy;
  logic                mulLast;
  logic [2*DATA_W-1:0] mulProduct;

  // Bus mux
  always_comb begin
    busVal = '0;
    case (bus_sel)
      CodeHi:  busVal = hiQ;
      CodeLo:  busVal = loQ;
      CodeZhi: busVal = zHiQ;
      CodeZlo: busVal = zLoQ;
      CodeExt: busVal = ext_in;
      default: begin
        if (bus_sel < CodeHi && !(bus_sel == '0 && ba_zero)) begin
          busVal = regFile[bus_sel[RA_W-1:0]];
        end
      end
    endcase
  end

  assign bus_out = busVal;

  // Single-cycle ALU: A = Y, B = bus; shift amounts are modulo DATA_W.
  assign shAmt = busVal[SH_W-1:0];
  assign shInv = -shAmt;

  always_comb begin
    aluResult = '0;
    case (alu_op_e'(alu_op))
      AluAdd:  aluResult = yQ + busVal;
      AluSub:  aluResult = yQ - busVal;
      AluAnd:  aluResult = yQ & busVal;
      AluOr:   aluResult = yQ | busVal;
      AluShr:  aluResult = yQ >> shAmt;
      AluShra: aluResult = $signed(yQ) >>> shAmt;
      AluShl:  aluResult = yQ << shAmt;
      AluRor:  aluResult = (yQ >> shAmt) | (yQ << shInv);
      AluRol:  aluResult = (yQ << shAmt) | (yQ >> shInv);
      AluNeg:  aluResult = -busVal;
      AluNot:  aluResult = ~busVal;
      default: aluResult = '0;
    endcase
  end

  assign startOk = alu_start && !mulBusy;
  assign isMul   = MulEn && (alu_op == AluMul);

`ifdef DP_MUL_EN
  dp_mul #(
    .DATA_W (DATA_W)
  ) uMul (
    .clk     (clk),
    .reset   (reset),
    .start   (startOk && isMul),
    .opA     (yQ),
    .opB     (busVal),
    .busy    (mulBusy),
    .last    (mulLast),
    .product (mulProduct)
  );
`else
  assign mulBusy    = 1'b0;
  assign mulLast    = 1'b0;
  assign mulProduct = '0;
`endif

  assign alu_busy = mulBusy;
  assign alu_done = doneQ;

  // Register bank, HI/LO and Y all capture the current bus value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regFile[i] <= '0;
      end
      hiQ <= '0;
      loQ <= '0;
      yQ  <= '0;
    end else begin
      if (reg_wr_en && ({1'b0, reg_wr_addr} < (RA_W + 1)'(NREG))) begin
        regFile[reg_wr_addr] <= busVal;
      end
      if (hi_in) hiQ <= busVal;
      if (lo_in) loQ <= busVal;
      if (y_in)  yQ  <= busVal;
    end
  end

  // Z and completion pulse; the multiplier owns Z only at its final edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zHiQ  <= '0;
      zLoQ  <= '0;
      doneQ <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      if (mulLast) begin
        {zHiQ, zLoQ} <= mulProduct;
        doneQ        <= 1'b1;
      end else if (startOk && !isMul) begin
        zHiQ  <= '0;
        zLoQ  <= aluResult;
        doneQ <= 1'b1;
      end
    end
  end

endmodule

// File: doc/bus_datapath.md
# bus_datapath

Parametrised single-bus CPU datapath core: a general-purpose register bank, HI/LO, Y and a 2×DATA_W Z register share one encoded-select bus. It also contains an ALU with single-cycle logic and shift operations and an iterative signed multiplier with a busy/done handshake. It sits under the control unit, which drives the select, write and start strobes. It is the parametrised successor of the fixed 32-bit, 16-register datapath.

## Interface
Parameters:
- DATA_W, 32, datapath width (≥8, power of two)
- NREG, 16, number of general-purpose registers (≥2)
- SEL_W, $clog2(NREG+5), bus select width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- bus_sel  in  SEL_W  bus source select
- ext_in  in  DATA_W  external source (MDR/port/PC/immediate)
- ba_zero  in  1  register 0 reads as zero when high
- reg_wr_en  in  1  write bus into register reg_wr_addr
- reg_wr_addr  in  $clog2(NREG)  destination register
- y_in, hi_in, lo_in  in  1  load bus into Y / HI / LO
- alu_op  in  4  operation code
- alu_start  in  1  start ALU op: Z ← op(Y, bus)
- bus_out  out  DATA_W  current bus value
- alu_busy  out  1  multiply in progress
- alu_done  out  1  one-cycle completion pulse

## Operation
- Bus select codes:
  - 0..NREG-1: registers.
  - NREG: HI. NREG+1: LO. NREG+2: ZHI. NREG+3: ZLO. NREG+4: ext_in.
  - Any other code drives 0.
  - Code 0 reads 0 while ba_zero is high.
- bus_out is combinational from bus_sel and register state.
- Writes capture bus_out at the clock edge. Multiple write strobes in one cycle all load the same bus value.
- ALU operand A = Y, operand B = bus.
- Opcodes:
  - 0 ADD, 1 SUB (A−B), 2 AND, 3 OR
  - 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL: A shifted by B[$clog2(DATA_W)-1:0], so amounts are modulo DATA_W
  - 9 NEG (−B), 10 NOT (~B)
  - 11 MUL: signed A×B, full 2×DATA_W result
  - 12–15 reserved: result 0
- Non-MUL ops write the result to ZLO and 0 to ZHI. Results are modulo 2^DATA_W and no flags are produced.
- MUL:
  - Radix-2 signed shift-add.
  - A and B are latched at the start edge, so later Y or bus changes do not affect the result.
  - The result goes to ZHI:ZLO.

## Timing
- Reset values:
  - All registers, HI, LO, Y and Z are 0.
  - alu_busy = 0, alu_done = 0.
  - bus_out is therefore 0 for every select except ext_in.
- Single-cycle ops: Z is loaded at the edge where alu_start is sampled. alu_done is high for the following cycle.
- MUL latency:
  - alu_busy rises after the start edge and stays high for DATA_W cycles.
  - Z is loaded at the last busy edge.
  - alu_done pulses the cycle after Z is loaded; alu_busy is low in that cycle.
- alu_start while alu_busy is high is ignored: no restart and no extra done pulse.
- Z is not disturbed mid-multiply.
- Register, Y, HI and LO writes are allowed while busy.
- alu_start in the same cycle as alu_done is accepted.
- Read and write of the same register in one cycle: bus shows the old value, and the register loads the bus value.
- Reset asserted mid-multiply aborts it: busy=0, done=0, Z=0, no pulse after release.

## Configuration
- DP_MUL_EN defined: the iterative multiplier is built as described above.
- DP_MUL_EN undefined:
  - Opcode 11 behaves as reserved: Z=0, done after 1 cycle.
  - alu_busy is tied to 0.
  - The multiplier logic is absent.

## Structure
- Package dp_pkg holds:
  - the alu_op enum (ADD..MUL, RESERVED)
  - the bus-select offset constants (SEL_HI, SEL_LO, SEL_ZHI, SEL_ZLO, SEL_EXT) relative to NREG
- Sub-module dp_mul: iterative signed multiplier with start/busy/done and a 2×DATA_W product, instantiated only under DP_MUL_EN.
- The rest (register bank, bus mux, single-cycle ALU, Z control) is in bus_datapath.

## Test plan
- **Reset:** after reset release, with bus_sel = each register/HI/LO/ZHI/ZLO, bus_out=0 and alu_busy=alu_done=0.
- **Load and ADD:** ext_in=5 → Y, ext_in=7 → R3; alu_op=ADD with bus_sel=R3 → ZLO=12 and ZHI=0, with done the next cycle.
- **Multiply:** Y=7, bus=−3 (0xFFFFFFFD), MUL → busy for 32 cycles, then ZHI=0xFFFFFFFF, ZLO=0xFFFFFFEB and a single done pulse; a second alu_start mid-run is ignored.
- **Rotate and R0:** Y=0x80000001, bus=36 → ROR yields 0x18000000. R0 loaded with 9 and ba_zero=1 → bus reads 0; with ba_zero=0 → bus reads 9.
- **Reset mid-multiply:** reset asserted at cycle 10 of MUL → Z=0 and busy=0 immediately, with no done pulse after release.
- **MUL compiled out:** without DP_MUL_EN, MUL gives Z=0, done after 1 cycle, and busy never rises.
